// File: rtl/jpeg_stream_framer.sv
// jpeg_stream_framer: wraps compressor bytes with an EBR-held JFIF header and a trailing FF D9 EOI marker
module jpeg_stream_framer #(
    parameter int HEADER_LEN     = 328,
    parameter int HDR_ADDR_WIDTH = 9,
    parameter int FIFO_AW        = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic [HDR_ADDR_WIDTH-1:0] header_ebr_raddr,
    output logic                      header_ebr_ren,
    output logic                      header_ebr_rclk,
    input  logic [7:0]                header_ebr_dout,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      busy,
    output logic                      dropped
);
    typedef enum logic [2:0] {IDLE, HEADER, STREAM, EOI_FF, EOI_D9} state_t;
    localparam logic [HDR_ADDR_WIDTH:0] HDR_END = (HDR_ADDR_WIDTH + 1)'(HEADER_LEN);

    state_t                  state, state_nx;
    logic [HDR_ADDR_WIDTH:0] cnt;
    logic [7:0]              mem [2**FIFO_AW];
    logic [FIFO_AW:0]        wp, rp;
    logic [7:0]              pop_data;
    logic                    empty, full, push, pop, drop, hdr_last;
    logic                    end_pending, hdr_vld, hdr_sof, pop_vld;

    assign empty            = wp == rp;
    assign full             = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    assign hdr_last         = cnt == HDR_END;
    assign pop              = state == STREAM && !empty;
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push             = in_valid && (state == HEADER || state == STREAM) && (!full || pop);
    assign drop             = in_valid && !push;
    assign header_ebr_ren   = state == HEADER && !hdr_last;
    assign header_ebr_raddr = cnt[HDR_ADDR_WIDTH-1:0];
    assign header_ebr_rclk  = clock;
    assign busy             = state != IDLE;
    // header bytes come straight from the EBR's registered output; EOI bytes are decoded from state
    assign out_valid        = hdr_vld || pop_vld || state == EOI_FF || state == EOI_D9;
    assign out_data         = hdr_vld ? header_ebr_dout : state == EOI_FF ? 8'hFF :
                              state == EOI_D9 ? 8'hD9 : pop_data;
    assign out_sof          = hdr_sof;
    assign out_eof          = state == EOI_D9;

    // next-state decode; HEADER holds one extra cycle so the last EBR byte is emitted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? HEADER : IDLE;
            HEADER:  state_nx = hdr_last ? STREAM : HEADER;
            STREAM:  state_nx = (end_pending && empty && !in_valid) ? EOI_FF : STREAM;
            EOI_FF:  state_nx = EOI_D9;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // header read counter and the one-cycle-delayed header output strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            hdr_vld <= 1'b0;
            hdr_sof <= 1'b0;
        end else begin
            cnt     <= header_ebr_ren ? cnt + 1'b1 : '0;
            hdr_vld <= header_ebr_ren;
            hdr_sof <= header_ebr_ren && cnt == '0;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clock) begin
        if (push) mem[wp[FIFO_AW-1:0]] <= in_data;
    end

    // FIFO pointers and registered pop output
    always_ff @(posedge clock) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            pop_vld  <= 1'b0;
            pop_data <= 8'h00;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp       <= rp + 1'b1;
                pop_data <= mem[rp[FIFO_AW-1:0]];
            end
            pop_vld <= pop;
        end
    end

    // frame-level flags: pending end-of-frame and sticky drop indicator
    always_ff @(posedge clock) begin
        if (reset) begin
            end_pending <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            end_pending <= (state == IDLE && frame_start) ? 1'b0 :
                           end_pending || (frame_end && (state == HEADER || state == STREAM));
            dropped     <= ((state == IDLE && frame_start) ? 1'b0 : dropped) || drop;
        end
    end
endmodule

// File: tb/tb_jpeg_stream_framer.sv
// tb_jpeg_stream_framer: directed frames with a queue-based scoreboard checking every output byte and its cycle
module tb_jpeg_stream_framer;
    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, frame_start, frame_end, in_valid;
    logic [7:0] in_data;
    logic [8:0] raddr;
    logic       ren, rclk;
    logic [7:0] dout = 8'h00;
    logic       out_valid, out_sof, out_eof, busy, dropped;
    logic [7:0] out_data;
    logic [7:0] rom [4] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0};
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    exp_t       e;

    jpeg_stream_framer #(.HEADER_LEN(4), .HDR_ADDR_WIDTH(9), .FIFO_AW(2)) dut (
        .clock(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
        .in_valid(in_valid), .in_data(in_data), .header_ebr_raddr(raddr),
        .header_ebr_ren(ren), .header_ebr_rclk(rclk), .header_ebr_dout(dout),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // cycle counter: value n names the interval after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // header EBR model with one-cycle read latency
    always @(posedge rclk) begin
        if (ren) dout <= (raddr < 9'd4) ? rom[raddr[1:0]] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic sof, input logic eof, input int c);
        sb.push_back('{d: d, sof: sof, eof: eof, cyc: c});
    endtask

    task automatic push_hdr(input int c);
        for (int i = 0; i < 4; i++) push_exp(rom[i], i == 0, 1'b0, c + i);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: pops the scoreboard on every output byte, flags overdue or unexpected bytes
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte @cycle %0d: got %0h expected no output", cyc, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                    chk("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
                    chk("out_eof", {31'd0, out_eof}, {31'd0, e.eof});
                    chk("out_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing_byte @cycle %0d: got none expected %0h at cycle %0d", cyc, sb[0].d, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        goto(1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_sof_eof", {30'd0, out_sof, out_eof}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dropped", {31'd0, dropped}, 0);
        chk("rst_ren_raddr", {22'd0, ren, raddr}, 0);
        goto(3); reset = 1'b0;
        // byte in IDLE is discarded; frame_end in IDLE is ignored
        goto(5); in_valid = 1'b1; in_data = 8'h99;
        goto(6); in_valid = 1'b0;
        chk("idle_drop", {31'd0, dropped}, 1);
        goto(7); frame_end = 1'b1;
        goto(8); frame_end = 1'b0;
        chk("idle_end_busy", {31'd0, busy}, 0);
        // frame 1: header, three early bytes buffered, EOI
        goto(10); frame_start = 1'b1; push_hdr(12);
        goto(11); frame_start = 1'b0;
        chk("f1_busy", {31'd0, busy}, 1);
        chk("f1_drop_clr", {31'd0, dropped}, 0);
        chk("f1_ren_raddr0", {22'd0, ren, raddr}, {22'd0, 1'b1, 9'd0});
        goto(12); in_valid = 1'b1; in_data = 8'h11; push_exp(8'h11, 0, 0, 17);
        goto(13); in_data = 8'h22; push_exp(8'h22, 0, 0, 18);
        goto(14); in_data = 8'h33; push_exp(8'h33, 0, 0, 19);
        goto(15); in_valid = 1'b0;
        goto(20); frame_end = 1'b1; push_exp(8'hFF, 0, 0, 22); push_exp(8'hD9, 0, 1, 23);
        goto(21); frame_end = 1'b0;
        goto(23); chk("f1_busy_d9", {31'd0, busy}, 1);
        goto(24); chk("f1_idle", {31'd0, busy}, 0);
        chk("f1_no_drop", {31'd0, dropped}, 0);
        // frame 2: 2-cycle latency on empty FIFO, ignored restart, end with byte in flight
        goto(40); frame_start = 1'b1; push_hdr(42);
        goto(41); frame_start = 1'b0;
        goto(50); in_valid = 1'b1; in_data = 8'h5A; push_exp(8'h5A, 0, 0, 52);
        goto(51); in_valid = 1'b0;
        goto(53); frame_start = 1'b1;
        goto(54); frame_start = 1'b0;
        chk("f2_restart_ignored", {30'd0, busy, ren}, {30'd0, 1'b1, 1'b0});
        goto(56); in_valid = 1'b1; in_data = 8'h77; frame_end = 1'b1;
        push_exp(8'h77, 0, 0, 58); push_exp(8'hFF, 0, 0, 59); push_exp(8'hD9, 0, 1, 60);
        goto(57); in_valid = 1'b0; frame_end = 1'b0;
        goto(61); chk("f2_idle", {31'd0, busy}, 0);
        // frame 3: overflow during header, push-on-full with pop in first STREAM cycle
        goto(70); frame_start = 1'b1; push_hdr(72);
        goto(71); frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            goto(71 + i);
            in_valid = 1'b1;
            in_data = 8'(8'hA1 + i);
            frame_end = (i == 2);
            if (i < 4) push_exp(8'(8'hA1 + i), 0, 0, 77 + i);
            if (i == 4) chk("f3_full_nodrop", {31'd0, dropped}, 0);
            if (i == 5) begin
                chk("f3_drop", {31'd0, dropped}, 1);
                push_exp(8'hA6, 0, 0, 81);
            end
        end
        goto(77); in_valid = 1'b0; frame_end = 1'b0;
        push_exp(8'hFF, 0, 0, 82); push_exp(8'hD9, 0, 1, 83);
        goto(84);
        chk("f3_idle", {31'd0, busy}, 0);
        chk("f3_drop_sticky", {31'd0, dropped}, 1);
        // frame 4: reset mid-header aborts, FIFO contents lost
        goto(90); frame_start = 1'b1;
        push_exp(8'hFF, 1, 0, 92); push_exp(8'hD8, 0, 0, 93); push_exp(8'hFF, 0, 0, 94);
        goto(91); frame_start = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
        goto(92); in_data = 8'hC2;
        goto(93); in_data = 8'hC3;
        goto(94); in_valid = 1'b0; reset = 1'b1;
        goto(95); reset = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_dropped", {31'd0, dropped}, 0);
        goto(100); frame_start = 1'b1; push_hdr(102);
        goto(101); frame_start = 1'b0;
        chk("f5_ren_raddr0", {22'd0, ren, raddr}, {22'd0, 1'b1, 9'd0});
        goto(102); chk("f5_raddr1", {23'd0, raddr}, 1);
        goto(106); frame_end = 1'b1; push_exp(8'hFF, 0, 0, 108); push_exp(8'hD9, 0, 1, 109);
        goto(107); frame_end = 1'b0;
        goto(112);
        chk("f5_idle", {31'd0, busy}, 0);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
